// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_SLT = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110,
    OP_MOD = 3'b111
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DIV  = 2'b10
  } state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/result bundle of the multi-cycle ALU, with requester and responder views.
interface multicycle_alu_if #(parameter int WIDTH = 32);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       aluop;
  logic [WIDTH-1:0] res;
  logic             done;
  logic             busy;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, a, b, aluop,
    input  res, done, busy, carry, overflow, zero, div_by_zero
  );

  modport slave (
    input  start, a, b, aluop,
    output res, done, busy, carry, overflow, zero, div_by_zero
  );

endinterface

// File: rtl/multicycle_alu_adder.sv
// Combinational WIDTH-bit adder with carry in/out; shared by ADD and SUB.
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/multicycle_alu_mod_iter.sv
// Restoring-division remainder engine: one quotient bit per clock, fin after WIDTH steps.
module mod_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem,
  output logic             fin
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_active;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // The partial remainder never exceeds 2*b-1, so one extra bit holds the trial difference sign.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_rem    <= '0;
      r_quo    <= a;
      r_div    <= b;
      r_cnt    <= CW'(WIDTH);
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt != '0) begin
        r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_active <= 1'b0;
      end
    end
  end

  assign rem = r_rem;
  assign fin = r_active && (r_cnt == '0);

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative unsigned MOD, registered result and flags.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SIGNED_SLT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluop,
  output logic [WIDTH-1:0] res,
  output logic             done,
  output logic             busy,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);

  state_e           r_state;
  aluop_e           r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_done, r_busy, r_carry, r_ovf, r_zero, r_dbz;

  logic             w_load, w_sub, w_cout, w_lt, w_fin;
  logic [WIDTH-1:0] w_add_b, w_sum, w_rem, w_res;
  logic             w_carry, w_ovf, w_dbz;

  assign w_load = (r_state == ST_IDLE) && start && (aluop == OP_MOD) && (b != '0);

  // SUB runs through the same adder as a + ~b + 1.
  assign w_sub   = (r_op == OP_SUB);
  assign w_add_b = w_sub ? ~r_b : r_b;

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a    (r_a),
    .i_b    (w_add_b),
    .i_cin  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  mod_iter #(.WIDTH(WIDTH)) u_mod (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .a     (a),
    .b     (b),
    .rem   (w_rem),
    .fin   (w_fin)
  );

  generate
    if (SIGNED_SLT != 0) begin : g_slt_signed
      assign w_lt = $signed(r_a) < $signed(r_b);
    end else begin : g_slt_unsigned
      assign w_lt = r_a < r_b;
    end
  endgenerate

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_dbz   = 1'b0;
    case (r_op)
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOR: w_res = ~(r_a | r_b);
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      OP_ADD, OP_SUB: begin
        w_res   = w_sum;
        w_carry = w_cout;
        w_ovf   = (r_a[WIDTH-1] == w_add_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      // Only a zero-divisor MOD reaches the single-cycle path.
      OP_MOD: begin
        w_res = r_a;
        w_dbz = 1'b1;
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_AND;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= aluop_e'(aluop);
            r_busy  <= 1'b1;
            r_state <= w_load ? ST_DIV : ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res   <= w_res;
          r_carry <= w_carry;
          r_ovf   <= w_ovf;
          r_zero  <= (w_res == '0);
          r_dbz   <= w_dbz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_DIV: begin
          if (w_fin) begin
            r_res   <= w_rem;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= (w_rem == '0);
            r_dbz   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign res         = r_res;
  assign done        = r_done;
  assign busy        = r_busy;
  assign carry       = r_carry;
  assign overflow    = r_ovf;
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: fixed vectors, multi-cycle corner sequences and randomized ops vs a model.
module tb_multicycle_alu;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(W)) bus ();

  logic [W-1:0] u_res;
  logic         u_done, u_busy, u_carry, u_overflow, u_zero, u_dbz;

  multicycle_alu #(.WIDTH(W), .SIGNED_SLT(1)) dut (
    .clk(clk), .reset(reset), .start(bus.start), .a(bus.a), .b(bus.b), .aluop(bus.aluop),
    .res(bus.res), .done(bus.done), .busy(bus.busy), .carry(bus.carry),
    .overflow(bus.overflow), .zero(bus.zero), .div_by_zero(bus.div_by_zero)
  );

  multicycle_alu #(.WIDTH(W), .SIGNED_SLT(0)) dut_u (
    .clk(clk), .reset(reset), .start(bus.start), .a(bus.a), .b(bus.b), .aluop(bus.aluop),
    .res(u_res), .done(u_done), .busy(u_busy), .carry(u_carry),
    .overflow(u_overflow), .zero(u_zero), .div_by_zero(u_dbz)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c, v, z, d;
    int           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res, res_u;
    logic         c, v, z, d;
    int           lat;
  } vec_t;

  // Reference behaviour from the arithmetic definitions of each opcode.
  function automatic exp_t model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, bit signed_slt);
    exp_t e;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint s;
    longint rs;
    e = '{res: '0, c: 1'b0, v: 1'b0, z: 1'b0, d: 1'b0, lat: 1};
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: e.res = a ^ b;
      3'd3: e.res = ~(a | b);
      3'd4: e.res = (signed_slt ? (sa < sb) : (a < b)) ? 1 : 0;
      3'd5: begin
        e.res = a + b;
        e.c = ({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF;
        s = sa + sb; rs = $signed(e.res); e.v = (s != rs);
      end
      3'd6: begin
        e.res = a - b;
        e.c = (a >= b);
        s = sa - sb; rs = $signed(e.res); e.v = (s != rs);
      end
      default: begin
        if (b == 0) begin
          e.res = a; e.d = 1'b1;
        end else begin
          e.res = a % b; e.lat = W + 1;
        end
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = op; bus.a = a; bus.b = b;
  endtask

  // Follows an operation from its accepting edge to done; scrambles inputs afterwards.
  task automatic wait_done(input int inject, output int lat, output logic busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.aluop = 3'($urandom_range(7));
    if (!bus.busy) busy_ok = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      bus.start = (k == inject);
      if (k == inject) begin
        bus.aluop = 3'd5; bus.a = 1; bus.b = 1;
      end
      if (bus.done) begin
        lat = k;
        if (bus.busy) busy_ok = 1'b0;
        bus.start = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e, input logic [W-1:0] eru,
                            input int lat, input logic busy_ok);
    $display("txn %s res=%h c=%0b v=%0b z=%0b dbz=%0b lat=%0d", tag, bus.res, bus.carry,
             bus.overflow, bus.zero, bus.div_by_zero, lat);
    chk({tag, ".lat"}, lat, e.lat);
    chk({tag, ".res"}, bus.res, e.res);
    chk({tag, ".carry"}, bus.carry, e.c);
    chk({tag, ".ovf"}, bus.overflow, e.v);
    chk({tag, ".zero"}, bus.zero, e.z);
    chk({tag, ".dbz"}, bus.div_by_zero, e.d);
    chk({tag, ".busy"}, busy_ok, 1'b1);
    chk({tag, ".res_u"}, u_res, eru);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[14];
    exp_t  e, eu;
    int    lat, dones;
    logic  bok;
    logic [2:0]   op;
    logic [W-1:0] ra, rb;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.aluop = '0;

    //                op     a             b             res           res_u         c     v     z     d     lat
    vecs[0]  = '{3'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'd6, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd7, 32'd100,      32'd7,        32'd2,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 33};
    vecs[3]  = '{3'd7, 32'h00001234, 32'h00000000, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[4]  = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd4, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{3'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd1, 32'h12340000, 32'h00005678, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'd2, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[9]  = '{3'd3, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{3'd5, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[11] = '{3'd6, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[12] = '{3'd7, 32'hFFFFFFFF, 32'd10,       32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 1'b0, 33};
    vecs[13] = '{3'd7, 32'd5,        32'd9,        32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 1'b0, 33};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.res", bus.res, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.flags", {bus.carry, bus.overflow, bus.zero, bus.div_by_zero}, 4'b0000);

    // First op goes in on the first edge after release; every later op issues in the done cycle.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        bus.start = 1'b1; bus.aluop = vecs[i].op; bus.a = vecs[i].a; bus.b = vecs[i].b;
      end else begin
        issue(vecs[i].op, vecs[i].a, vecs[i].b);
      end
      wait_done(-1, lat, bok);
      e = '{res: vecs[i].res, c: vecs[i].c, v: vecs[i].v, z: vecs[i].z, d: vecs[i].d, lat: vecs[i].lat};
      check_outs($sformatf("vec%0d", i), e, vecs[i].res_u, lat, bok);
    end

    // Remainder op with a second request arriving mid-flight; it must be dropped, not queued.
    issue(3'd7, 32'd100, 32'd7);
    wait_done(5, lat, bok);
    e = model(3'd7, 32'd100, 32'd7, 1'b1);
    check_outs("mod_ignore", e, e.res, lat, bok);
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("mod_ignore.no_queue", dones, 0);
    chk("mod_ignore.hold", bus.res, 32'd2);

    // Reset in the middle of a MOD, then an ADD on the first edge after release.
    issue(3'd7, 32'd100, 32'd7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort.res", bus.res, 0);
    chk("abort.busy", bus.busy, 0);
    chk("abort.done", bus.done, 0);
    chk("abort.flags", {bus.carry, bus.overflow, bus.zero, bus.div_by_zero}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1; bus.aluop = 3'd5; bus.a = 32'd2; bus.b = 32'd3;
    wait_done(-1, lat, bok);
    e = model(3'd5, 32'd2, 32'd3, 1'b1);
    check_outs("after_rst", e, e.res, lat, bok);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("abort.no_stale_done", dones, 0);

    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(7));
      ra = $urandom;
      case ($urandom_range(3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(3) == 0) ra = W'($urandom_range(255));
      e  = model(op, ra, rb, 1'b1);
      eu = model(op, ra, rb, 1'b0);
      issue(op, ra, rb);
      wait_done(-1, lat, bok);
      check_outs($sformatf("rnd%0d op%0d a=%h b=%h", n, op, ra, rb), e, eu.res, lat, bok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter SIGNED_SLT, default 1, meaning SLT compares two's-complement when 1 and unsigned when 0.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning request: operands and opcode are valid this cycle.
REQ-006 SHALL have ports a and b, input, WIDTH each, meaning operands.
REQ-007 SHALL have port aluop, input, 3, meaning opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD.
REQ-008 SHALL have port res, output, WIDTH, meaning registered result.
REQ-009 SHALL have port done, output, 1, meaning one-cycle pulse marking res and the flags valid.
REQ-010 SHALL have port busy, output, 1, meaning an accepted operation is in progress.
REQ-011 SHALL have ports carry, overflow, zero and div_by_zero, output, 1 each, meaning registered status flags.

Function
REQ-012 SHALL accept start only when busy=0; a, b and aluop are latched on acceptance and later input changes have no effect.
REQ-013 SHALL ignore start while busy=1; no queueing and no error flag.
REQ-014 SHALL implement FSM IDLE -> EXEC on accepted non-MOD op; IDLE -> DIV on accepted MOD with b!=0; IDLE -> EXEC on MOD with b=0; EXEC -> IDLE; DIV -> IDLE after WIDTH iterations.
REQ-015 SHALL, for non-MOD ops and MOD with b=0, assert done exactly 1 cycle after the accepting edge (latency 1).
REQ-016 SHALL, for MOD with b!=0, compute a mod b (unsigned) by restoring division, one quotient bit per cycle, and assert done exactly WIDTH+1 cycles after the accepting edge.
REQ-017 SHALL hold busy=1 from the cycle after acceptance up to and including the cycle before done; busy=0 while done=1.
REQ-018 SHALL accept a start presented in the same cycle as done (back-to-back issue).
REQ-019 SHALL compute ADD/SUB modulo 2^WIDTH; SUB = a + ~b + 1; carry = carry-out of that adder (SUB: 1 means no borrow).
REQ-020 SHALL set overflow to signed overflow for ADD/SUB, 0 otherwise.
REQ-021 SHALL drive SLT as res = {WIDTH-1 zeros, lt}.
REQ-022 SHALL set zero=1 when the completed res equals 0, for every op.
REQ-023 SHALL, for MOD with b=0, return res=a and div_by_zero=1; div_by_zero=0 for every other completion.
REQ-024 SHALL update res and all flags only on the done cycle and hold them until the next done; carry/overflow=0 for logic, SLT and MOD ops.

Reset
REQ-025 SHALL, while reset=0, force the FSM to IDLE and clear res, done, busy, carry, overflow, zero and div_by_zero to 0, independent of clk.
REQ-026 SHALL abort any in-flight operation on reset, with no done pulse for that operation after release.
REQ-027 SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL take opcode encodings and FSM state encodings from shared package alu_pkg.
REQ-029 SHALL place the iterative remainder datapath in sub-module mod_iter (ports: clk, reset, load, a, b, WIDTH parameter, rem, fin).
REQ-030 SHALL reuse the existing combinational adder for ADD/SUB, with one instance shared by both ops.

Verification (WIDTH=32)
REQ-031 SHALL cover ADD a=0xFFFFFFFF, b=1 -> done at +1, res=0, carry=1, zero=1, overflow=0.
REQ-032 SHALL cover SUB a=0x7FFFFFFF, b=0xFFFFFFFF -> res=0x80000000, overflow=1, carry=0.
REQ-033 SHALL cover MOD a=100, b=7 -> busy high 32 cycles, done at +33, res=2; with a second start at +5, that start is ignored.
REQ-034 SHALL cover MOD a=0x1234, b=0 -> done at +1, res=0x1234, div_by_zero=1.
REQ-035 SHALL cover SLT a=0xFFFFFFFF, b=1 -> res=1 (SIGNED_SLT=1), res=0 (SIGNED_SLT=0).
REQ-036 SHALL cover reset asserted at +10 of MOD -> all outputs 0 immediately, no done afterwards; ADD issued the first cycle after release completes at +1.
